// File: rtl/simple_spi_slave.sv
// SPI target with an 8-bit WISHBONE register file. sck/ss_n/mosi are oversampled in clk_i;
// received bytes queue in an RX FIFO and reply bytes are taken from a TX FIFO. Modes 0-3, MSB first.
module simple_spi_slave_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       empty_o,
    output logic       full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_q, wr_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_push = push_i & ~full_o & ~flush_i;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_q];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end
endmodule

module simple_spi_slave #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       cyc_i,
    input  logic       stb_i,
    input  logic [1:0] adr_i,
    input  logic       we_i,
    input  logic [7:0] dat_i,
    output logic [7:0] dat_o,
    output logic       ack_o,
    output logic       inta_o,
    input  logic       sck_i,
    input  logic       ss_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe_o
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic       sck_prev_q, ss_prev_q;
    logic [7:0] ctrl_q, ctrl_d, dat_q, dat_d, txsr_q, txsr_d, rxsr_q, rxsr_d;
    logic       spif_q, wcol_q, rovr_q, urun_q, spif_d, wcol_d, rovr_d, urun_d;
    logic       ack_q, ack_d, inta_q, inta_d, rd_pop_q, rd_pop_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic       load_pend_q, load_pend_d, tx_valid_q, tx_valid_d;
    logic       spif_set, rovr_set, urun_set, wcol_set;
    logic [3:0] flag_clr;

    logic       spie, spe, cpol, cpha, sck_s, ss_s, mosi_s;
    logic       sck_edge, lead_edge, trail_edge, sample_edge, shift_edge, ss_fall, ss_rise;
    logic       bus_req, bus_acc, tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] tx_head, rx_head, tx_load;
    logic       tx_empty, tx_full, rx_empty, rx_full;

    assign spie        = ctrl_q[7];
    assign spe         = ctrl_q[6];
    assign cpol        = ctrl_q[3];
    assign cpha        = ctrl_q[2];
    assign sck_s       = sck_sync_q[SYNC_STAGES-1];
    assign ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    // Leading edge leaves the idle (cpol) level, trailing edge returns to it.
    assign sck_edge    = sck_s ^ sck_prev_q;
    assign lead_edge   = sck_edge & (sck_s != cpol);
    assign trail_edge  = sck_edge & (sck_s == cpol);
    assign sample_edge = cpha ? trail_edge : lead_edge;
    assign shift_edge  = cpha ? lead_edge : trail_edge;
    assign ss_fall     = ss_prev_q & ~ss_s;
    assign ss_rise     = ~ss_prev_q & ss_s;
    assign bus_req     = cyc_i & stb_i;
    assign bus_acc     = ack_q & bus_req;
    assign tx_load     = tx_empty ? 8'h00 : tx_head;

    simple_spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(~spe), .push_i(tx_push), .wdata_i(dat_i),
        .pop_i(tx_pop), .head_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
    );

    simple_spi_slave_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(~spe), .push_i(rx_push),
        .wdata_i({rxsr_q[6:0], mosi_s}), .pop_i(rx_pop), .head_o(rx_head),
        .empty_o(rx_empty), .full_o(rx_full)
    );

    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        load_pend_d = load_pend_q;
        tx_valid_d  = tx_valid_q;
        txsr_d      = txsr_q;
        rxsr_d      = rxsr_q;
        tx_pop      = 1'b0;
        rx_push     = 1'b0;
        spif_set    = 1'b0;
        rovr_set    = 1'b0;
        urun_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (spe && ss_fall) begin
                    state_d = ACTIVE;
                    bcnt_d  = 3'd0;
                    if (cpha) begin
                        load_pend_d = 1'b1;
                    end else begin
                        txsr_d      = tx_load;
                        tx_valid_d  = ~tx_empty;
                        load_pend_d = 1'b0;
                    end
                end
            end
            ACTIVE: begin
                if (!spe || ss_rise) begin
                    state_d     = IDLE;
                    bcnt_d      = 3'd0;
                    load_pend_d = 1'b0;
                end else if (!ss_s) begin
                    if (shift_edge) begin
                        if (load_pend_q) begin
                            txsr_d      = tx_load;
                            tx_valid_d  = ~tx_empty;
                            load_pend_d = 1'b0;
                        end else begin
                            txsr_d = {txsr_q[6:0], 1'b0};
                        end
                    end
                    if (sample_edge) begin
                        rxsr_d = {rxsr_q[6:0], mosi_s};
                        bcnt_d = bcnt_q + 3'd1;
                        // The TX byte is only consumed once its first bit has gone out.
                        if (bcnt_q == 3'd0) begin
                            tx_pop   = tx_valid_q;
                            urun_set = ~tx_valid_q;
                        end
                        if (bcnt_q == 3'd7) begin
                            rx_push     = ~rx_full;
                            rovr_set    = rx_full;
                            spif_set    = 1'b1;
                            load_pend_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!spe) begin
            txsr_d      = 8'h00;
            rxsr_d      = 8'h00;
            bcnt_d      = 3'd0;
            load_pend_d = 1'b0;
        end
    end

    always_comb begin
        ack_d    = bus_req & ~ack_q;
        dat_d    = dat_q;
        rd_pop_d = 1'b0;
        ctrl_d   = ctrl_q;
        tx_push  = 1'b0;
        wcol_set = 1'b0;
        flag_clr = 4'b0000;
        // Read data is captured as ack is raised; the RX pop itself waits for the ack cycle.
        if (bus_req && !ack_q) begin
            case (adr_i)
                2'b00:   dat_d = ctrl_q;
                2'b01:   dat_d = {spif_q, wcol_q, rovr_q, urun_q, tx_full, tx_empty, rx_full, rx_empty};
                2'b10:   dat_d = rx_head;
                default: dat_d = 8'h00;
            endcase
            rd_pop_d = ~we_i & (adr_i == 2'b10) & ~rx_empty;
        end
        if (bus_acc && we_i) begin
            case (adr_i)
                2'b00:   ctrl_d = dat_i & 8'hCC;
                2'b01:   flag_clr = dat_i[7:4];
                2'b10:   begin
                    tx_push  = ~tx_full;
                    wcol_set = tx_full;
                end
                default: ;
            endcase
        end
        rx_pop = ack_q & rd_pop_q;
        spif_d = (spif_q & ~flag_clr[3]) | spif_set;
        wcol_d = (wcol_q & ~flag_clr[2]) | wcol_set;
        rovr_d = (rovr_q & ~flag_clr[1]) | rovr_set;
        urun_d = (urun_q & ~flag_clr[0]) | urun_set;
        inta_d = spie & (spif_q | rovr_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
            state_q     <= IDLE;
            ctrl_q      <= 8'h00;
            dat_q       <= 8'h00;
            ack_q       <= 1'b0;
            inta_q      <= 1'b0;
            rd_pop_q    <= 1'b0;
            {spif_q, wcol_q, rovr_q, urun_q} <= 4'b0000;
            bcnt_q      <= 3'd0;
            load_pend_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            txsr_q      <= 8'h00;
            rxsr_q      <= 8'h00;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sck_prev_q  <= sck_s;
            ss_prev_q   <= ss_s;
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            dat_q       <= dat_d;
            ack_q       <= ack_d;
            inta_q      <= inta_d;
            rd_pop_q    <= rd_pop_d;
            {spif_q, wcol_q, rovr_q, urun_q} <= {spif_d, wcol_d, rovr_d, urun_d};
            bcnt_q      <= bcnt_d;
            load_pend_q <= load_pend_d;
            tx_valid_q  <= tx_valid_d;
            txsr_q      <= txsr_d;
            rxsr_q      <= rxsr_d;
        end
    end

    assign dat_o     = dat_q;
    assign ack_o     = ack_q;
    assign inta_o    = inta_q;
    assign miso_o    = txsr_q[7];
    assign miso_oe_o = spe & ~ss_s;
endmodule

// File: tb/tb_simple_spi_slave.sv
// Bench for simple_spi_slave: a bit-banged SPI master and WISHBONE master against a
// queue-based model of the byte stream, FIFO occupancy and status flags.
module tb_simple_spi_slave;
    localparam int DEPTH = 4;
    localparam int HALF  = 5;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
    logic [1:0] adr_i = 2'b00;
    logic [7:0] dat_i = 8'h00;
    logic [7:0] dat_o;
    logic       ack_o, inta_o, miso_o, miso_oe_o;
    logic       sck_i = 1'b0, ss_n_i = 1'b1, mosi_i = 1'b0;

    always #5 clk_i = ~clk_i;

    simple_spi_slave #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .adr_i(adr_i),
        .we_i(we_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .inta_o(inta_o),
        .sck_i(sck_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe_o(miso_oe_o)
    );

    typedef struct {
        logic [1:0] mode;
        logic       tx_en;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] exp_mi;
        logic [7:0] exp_stat;
    } vec_t;

    int         n_vec = 0, n_err = 0;
    logic [7:0] tx_q[$], rx_q[$];
    logic       m_spif = 0, m_wcol = 0, m_rovr = 0, m_urun = 0;
    logic [7:0] m_ctrl = 8'h00;
    logic       cpol_m = 0, cpha_m = 0;
    logic [7:0] mo_buf[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_stat();
        return {m_spif, m_wcol, m_rovr, m_urun, tx_q.size() == DEPTH, tx_q.size() == 0,
                rx_q.size() == DEPTH, rx_q.size() == 0};
    endfunction

    task automatic m_take_tx(output logic [7:0] b);
        if (tx_q.size() > 0) b = tx_q.pop_front();
        else begin
            b = 8'h00;
            m_urun = 1'b1;
        end
    endtask

    task automatic m_byte_done(input logic [7:0] mo);
        if (rx_q.size() < DEPTH) rx_q.push_back(mo);
        else m_rovr = 1'b1;
        m_spif = 1'b1;
    endtask

    task automatic m_reset();
        tx_q.delete();
        rx_q.delete();
        {m_spif, m_wcol, m_rovr, m_urun} = 4'b0000;
        m_ctrl = 8'h00;
    endtask

    task automatic bus_cycle(input logic [1:0] a, input logic w, input logic [7:0] wd,
                             output logic [7:0] rd);
        int n = 0;
        cyc_i = 1'b1; stb_i = 1'b1; adr_i = a; we_i = w; dat_i = wd;
        do begin
            @(posedge clk_i); #1;
            n++;
        end while (!ack_o && n < 8);
        check("bus_ack", ack_o, 1'b1);
        rd = dat_o;
        @(posedge clk_i); #1;
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] wd);
        logic [7:0] unused;
        bus_cycle(a, 1'b1, wd, unused);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] rd);
        bus_cycle(a, 1'b0, 8'h00, rd);
    endtask

    task automatic half();
        repeat (HALF) @(posedge clk_i);
        #1;
    endtask

    task automatic set_ctrl(input logic [7:0] c);
        bus_write(2'b00, c);
        m_ctrl = c & 8'hCC;
        if (!c[6]) begin
            tx_q.delete();
            rx_q.delete();
        end
        cpol_m = c[3];
        cpha_m = c[2];
        sck_i  = cpol_m;
        half();
    endtask

    task automatic tx_write(input logic [7:0] b);
        bus_write(2'b10, b);
        if (tx_q.size() == DEPTH) m_wcol = 1'b1;
        else tx_q.push_back(b);
    endtask

    task automatic rx_read_check(input string name);
        logic [7:0] d;
        bus_read(2'b10, d);
        if (rx_q.size() > 0) check(name, d, rx_q.pop_front());
    endtask

    task automatic stat_check(input string name);
        logic [7:0] d;
        bus_read(2'b01, d);
        check(name, d, m_stat());
    endtask

    task automatic inta_check(input string name);
        repeat (2) @(posedge clk_i);
        #1;
        check(name, inta_o, m_ctrl[7] & (m_spif | m_rovr));
    endtask

    task automatic clear_flags();
        bus_write(2'b01, 8'hF0);
        {m_spif, m_wcol, m_rovr, m_urun} = 4'b0000;
    endtask

    task automatic ss_begin();
        ss_n_i = 1'b0;
        half(); half();
    endtask

    task automatic ss_end();
        half();
        ss_n_i = 1'b1;
        half(); half();
    endtask

    task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha_m) begin
                mosi_i = mo[i];
                half();
                sck_i = ~cpol_m;
                mi[i] = miso_o;
                half();
                sck_i = cpol_m;
            end else begin
                sck_i  = ~cpol_m;
                mosi_i = mo[i];
                half();
                sck_i = cpol_m;
                mi[i] = miso_o;
                half();
            end
        end
    endtask

    task automatic session(input int n);
        logic [7:0] exp, mi;
        ss_begin();
        check("miso_oe_active", miso_oe_o, 1'b1);
        for (int k = 0; k < n; k++) begin
            m_take_tx(exp);
            spi_bits(mo_buf[k], 8, mi);
            m_byte_done(mo_buf[k]);
            check("miso_byte", mi, exp);
        end
        ss_end();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[6];
        logic [7:0] b, mi, d;
        logic [1:0] m;
        int         nb, nr, nt;

        tbl[0] = '{2'd0, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h84};
        tbl[1] = '{2'd1, 1'b1, 8'h5A, 8'hC3, 8'h5A, 8'h84};
        tbl[2] = '{2'd2, 1'b1, 8'h81, 8'h7E, 8'h81, 8'h84};
        tbl[3] = '{2'd3, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h84};
        tbl[4] = '{2'd0, 1'b0, 8'h00, 8'h55, 8'h00, 8'h94};
        tbl[5] = '{2'd3, 1'b0, 8'h00, 8'hAA, 8'h00, 8'h94};

        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        check("rst_dat_o", dat_o, 8'h00);
        check("rst_ack_o", ack_o, 1'b0);
        check("rst_inta_o", inta_o, 1'b0);
        check("rst_miso_o", miso_o, 1'b0);
        check("rst_miso_oe_o", miso_oe_o, 1'b0);
        stat_check("rst_stat");
        bus_read(2'b00, d);
        check("rst_ctrl", d, 8'h00);

        bus_write(2'b00, 8'hFF);
        bus_read(2'b00, d);
        check("ctrl_mask", d, 8'hCC);
        bus_write(2'b11, 8'hFF);
        bus_read(2'b11, d);
        check("reserved_reg", d, 8'h00);
        m_ctrl = 8'hCC;

        for (int r = 0; r < 6; r++) begin
            set_ctrl({1'b0, 1'b1, 2'b00, tbl[r].mode, 2'b00});
            clear_flags();
            if (tbl[r].tx_en) tx_write(tbl[r].tx);
            ss_begin();
            m_take_tx(b);
            spi_bits(tbl[r].mo, 8, mi);
            m_byte_done(tbl[r].mo);
            ss_end();
            check("tbl_miso", mi, tbl[r].exp_mi);
            bus_read(2'b01, d);
            check("tbl_stat", d, tbl[r].exp_stat);
            bus_read(2'b10, d);
            void'(rx_q.pop_front());
            check("tbl_rx", d, tbl[r].mo);
            if (!tbl[r].tx_en) begin
                bus_write(2'b01, 8'h10);
                m_urun = 1'b0;
                bus_read(2'b01, d);
                check("tbl_urun_clr", d, 8'h85);
            end
        end

        for (int md = 1; md < 4; md++) begin
            set_ctrl({1'b0, 1'b1, 2'b00, 2'(md), 2'b00});
            clear_flags();
            mo_buf[0] = 8'h01; mo_buf[1] = 8'h02; mo_buf[2] = 8'h04; mo_buf[3] = 8'h80;
            for (int k = 0; k < 4; k++) tx_write(mo_buf[k]);
            session(4);
            for (int k = 0; k < 4; k++) rx_read_check("echo_rx");
            stat_check("echo_stat");
        end

        set_ctrl(8'hC0);
        clear_flags();
        for (int k = 0; k < 5; k++) mo_buf[k] = 8'(k + 1);
        session(5);
        stat_check("ovr_stat");
        inta_check("ovr_inta");
        for (int k = 0; k < 4; k++) rx_read_check("ovr_rx");
        stat_check("ovr_stat_drained");

        set_ctrl(8'h40);
        clear_flags();
        tx_write(8'h11);
        tx_write(8'h22);
        ss_begin();
        m_take_tx(b);
        spi_bits(8'hF0, 4, mi);
        check("partial_miso", mi[7:4], b[7:4]);
        ss_end();
        stat_check("partial_stat");
        mo_buf[0] = 8'h9C;
        session(1);
        rx_read_check("realign_rx");
        stat_check("realign_stat");

        set_ctrl(8'h44);
        clear_flags();
        tx_write(8'hAA);
        tx_write(8'hBB);
        ss_begin();
        m_take_tx(b);
        spi_bits(8'h0F, 4, mi);
        bus_write(2'b00, 8'h00);
        m_ctrl = 8'h00;
        tx_q.delete();
        rx_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        check("spe_off_miso_oe", miso_oe_o, 1'b0);
        check("spe_off_miso", miso_o, 1'b0);
        stat_check("spe_off_stat");
        ss_n_i = 1'b1;
        half();

        set_ctrl(8'hC0);
        clear_flags();
        tx_write(8'hA5);
        tx_write(8'h5A);
        mo_buf[0] = 8'h3C;
        session(1);
        stat_check("pre_rst_stat");
        inta_check("pre_rst_inta");
        ss_begin();
        m_take_tx(b);
        spi_bits(8'hFF, 4, mi);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        m_reset();
        check("mid_rst_dat_o", dat_o, 8'h00);
        check("mid_rst_ack_o", ack_o, 1'b0);
        check("mid_rst_inta_o", inta_o, 1'b0);
        check("mid_rst_miso_o", miso_o, 1'b0);
        check("mid_rst_miso_oe_o", miso_oe_o, 1'b0);
        stat_check("mid_rst_stat");
        bus_read(2'b00, d);
        check("mid_rst_ctrl", d, 8'h00);
        ss_n_i = 1'b1;
        half();

        for (int it = 0; it < 15; it++) begin
            m  = 2'($urandom_range(0, 3));
            set_ctrl({1'($urandom_range(0, 1)), 1'b1, 2'b00, m, 2'b00});
            nt = $urandom_range(0, 5);
            for (int k = 0; k < nt; k++) tx_write(8'($urandom));
            nb = $urandom_range(1, 5);
            for (int k = 0; k < nb; k++) mo_buf[k] = 8'($urandom);
            session(nb);
            stat_check("rand_stat");
            inta_check("rand_inta");
            nr = $urandom_range(0, 5);
            for (int k = 0; k < nr; k++) rx_read_check("rand_rx");
            stat_check("rand_stat_after_rd");
            clear_flags();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
